// File: rtl/memoria_instrucoes_carregavel_if.sv
// Loader and fetch bus of the loadable instruction memory.
// The master side is the loader/CPU and the slave side is the memory.
interface memoria_instrucoes_carregavel_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 26
);
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              load_ready;
  logic              boot_done;
  logic [ADDR_W-1:0] pc;
  logic              fetch_en;
  logic [DATA_W-1:0] instrucao;
  logic              instr_valid;
  logic              addr_fault;

  modport master (
    output load_valid, load_data, load_last, pc, fetch_en,
    input  load_ready, boot_done, instrucao, instr_valid, addr_fault
  );

  modport slave (
    input  load_valid, load_data, load_last, pc, fetch_en,
    output load_ready, boot_done, instrucao, instr_valid, addr_fault
  );
endinterface

// File: rtl/memoria_instrucoes_carregavel.sv
// Boot-loadable instruction memory for the iZero core. A program is streamed in after reset and then fetched with a registered read.
// Defining IMEM_RELOAD_EN adds a reload input that returns the block to the load phase.
//
// state   | meaning
// ST_LOAD | accepting program words from the loader
// ST_RUN  | program loaded, serving fetches
module memoria_instrucoes_carregavel #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 26,
  parameter int DEPTH  = 256
) (
  input logic clock,
  input logic reset,
`ifdef IMEM_RELOAD_EN
  input logic reload,
`endif
  memoria_instrucoes_carregavel_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {ST_LOAD, ST_RUN} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0]  wptr, count;
  logic              reload_req;
  logic              xfer, last_word, fetch_ok, in_prog, pc_over;
  logic [IDX_W-1:0]  widx, ridx;

`ifdef IMEM_RELOAD_EN
  assign reload_req = reload;
`else
  assign reload_req = 1'b0;
`endif

  assign widx      = wptr[IDX_W-1:0];
  assign ridx      = bus.pc[IDX_W-1:0];
  assign last_word = bus.load_last || (wptr == CNT_W'(DEPTH - 1));
  // Full-width compares: an out-of-range pc must never alias a low word.
  assign in_prog   = bus.pc < ADDR_W'(count);
  assign pc_over   = bus.pc >= ADDR_W'(DEPTH);

  always_ff @(posedge clock) begin
    if (reset) state <= ST_LOAD;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_LOAD: if (!reload_req && xfer && last_word) state_nxt = ST_RUN;
      ST_RUN:  if (reload_req) state_nxt = ST_LOAD;
      default: state_nxt = ST_LOAD;
    endcase
  end

  always_comb begin
    bus.boot_done = (state == ST_RUN);
    xfer          = (state == ST_LOAD) && bus.load_valid && bus.load_ready && !reload_req;
    fetch_ok      = (state == ST_RUN) && bus.fetch_en && !reload_req;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr            <= '0;
      count           <= '0;
      bus.load_ready  <= 1'b0;
      bus.instrucao   <= '0;
      bus.instr_valid <= 1'b0;
      bus.addr_fault  <= 1'b0;
    end else begin
      bus.load_ready <= (state_nxt == ST_LOAD);
      if (reload_req) begin
        wptr            <= '0;
        count           <= '0;
        bus.instrucao   <= '0;
        bus.instr_valid <= 1'b0;
        bus.addr_fault  <= 1'b0;
      end else begin
        if (xfer) begin
          wptr  <= wptr + 1'b1;
          count <= count + 1'b1;
        end
        bus.instr_valid <= fetch_ok;
        if (fetch_ok) begin
          bus.instrucao <= in_prog ? mem[ridx] : '0;
          if (pc_over) bus.addr_fault <= 1'b1;
        end
      end
    end
  end

  // Storage is deliberately not reset; count gates visibility of stale words.
  always_ff @(posedge clock) begin
    if (!reset && xfer) mem[widx] <= bus.load_data;
  end
endmodule

// File: tb/tb_memoria_instrucoes_carregavel.sv
// Directed bench for memoria_instrucoes_carregavel: boot load, fetch table, full-depth load, mid-load reset and optional reload.
module tb_memoria_instrucoes_carregavel;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 26;
  localparam int DEPTH  = 256;

  logic clock = 1'b0;
  logic reset = 1'b1;
`ifdef IMEM_RELOAD_EN
  logic reload = 1'b0;
`endif

  memoria_instrucoes_carregavel_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) lb ();

  memoria_instrucoes_carregavel #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
`ifdef IMEM_RELOAD_EN
    .reload(reload),
`endif
    .bus   (lb.slave)
  );

  always #5 clock = ~clock;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic idle_inputs();
    lb.load_valid = 1'b0;
    lb.load_data  = '0;
    lb.load_last  = 1'b0;
    lb.fetch_en   = 1'b0;
    lb.pc         = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic load_word(input logic [31:0] d, input logic last);
    int n = 0;
    lb.load_valid = 1'b1;
    lb.load_data  = d;
    lb.load_last  = last;
    while (!lb.load_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n >= 50) chk("load_ready_timeout", 32'(lb.load_ready), 32'd1);
    @(negedge clock);
    lb.load_valid = 1'b0;
    lb.load_last  = 1'b0;
  endtask

  task automatic fetch(input logic [ADDR_W-1:0] a, input string name, input logic [31:0] exp);
    lb.fetch_en = 1'b1;
    lb.pc       = a;
    @(negedge clock);
    lb.fetch_en = 1'b0;
    chk({name, "_valid"}, 32'(lb.instr_valid), 32'd1);
    chk({name, "_data"}, lb.instrucao, exp);
  endtask

  typedef struct {
    logic              fe;
    logic [ADDR_W-1:0] pc;
    logic [31:0]       exp_instr;
    logic              exp_valid;
    logic              exp_fault;
  } vec_t;

  localparam logic [31:0] W_ADDI = 32'h0863_0001;
  localparam logic [31:0] W_LI   = 32'h5015_000A;
  localparam logic [31:0] W_HALT = 32'hFC00_0000;

  vec_t vecs [10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 26'd0,         W_ADDI, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 26'd1,         W_LI,   1'b1, 1'b0};
    vecs[2] = '{1'b1, 26'd2,         W_HALT, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 26'd0,         W_HALT, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 26'd5,         32'd0,  1'b1, 1'b0};
    vecs[5] = '{1'b1, 26'd255,       32'd0,  1'b1, 1'b0};
    vecs[6] = '{1'b1, 26'd256,       32'd0,  1'b1, 1'b1};
    vecs[7] = '{1'b1, 26'd0,         W_ADDI, 1'b1, 1'b1};
    vecs[8] = '{1'b1, 26'h200_0000,  32'd0,  1'b1, 1'b1};
    vecs[9] = '{1'b1, 26'd1,         W_LI,   1'b1, 1'b1};

    // Reset state and the first load-ready cycle.
    do_reset();
    chk("rst_load_ready", 32'(lb.load_ready), 32'd0);
    chk("rst_boot_done", 32'(lb.boot_done), 32'd0);
    chk("rst_instr_valid", 32'(lb.instr_valid), 32'd0);
    chk("rst_instrucao", lb.instrucao, 32'd0);
    chk("rst_addr_fault", 32'(lb.addr_fault), 32'd0);
    lb.fetch_en = 1'b1;
    @(negedge clock);
    lb.fetch_en = 1'b0;
    chk("load_ready_after_rst", 32'(lb.load_ready), 32'd1);
    chk("fetch_in_load_valid", 32'(lb.instr_valid), 32'd0);
    chk("fetch_in_load_data", lb.instrucao, 32'd0);

    load_word(W_ADDI, 1'b0);
    load_word(W_LI, 1'b0);
    chk("boot_done_mid", 32'(lb.boot_done), 32'd0);
    load_word(W_HALT, 1'b1);
    chk("boot_done_after_last", 32'(lb.boot_done), 32'd1);
    chk("load_ready_in_run", 32'(lb.load_ready), 32'd0);

    // Back-to-back fetch table.
    for (int i = 0; i < 10; i++) begin
      lb.fetch_en = vecs[i].fe;
      lb.pc       = vecs[i].pc;
      @(negedge clock);
      chk($sformatf("vec%0d_instr", i), lb.instrucao, vecs[i].exp_instr);
      chk($sformatf("vec%0d_valid", i), 32'(lb.instr_valid), 32'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_fault", i), 32'(lb.addr_fault), 32'(vecs[i].exp_fault));
    end
    lb.fetch_en = 1'b0;

    // Full-depth stream without load_last.
    do_reset();
    @(negedge clock);
    lb.load_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      lb.load_data = 32'hA500_0000 | 32'(i);
      @(negedge clock);
    end
    chk("full_boot_done", 32'(lb.boot_done), 32'd1);
    chk("full_load_ready", 32'(lb.load_ready), 32'd0);
    lb.load_data = 32'hDEAD_BEEF;
    @(negedge clock);
    lb.load_valid = 1'b0;
    fetch(26'd255, "full_w255", 32'hA500_00FF);
    fetch(26'd0, "full_w0", 32'hA500_0000);
    fetch(26'd128, "full_w128", 32'hA500_0080);

    // Gappy load interrupted by reset after two words.
    do_reset();
    @(negedge clock);
    lb.load_valid = 1'b1; lb.load_data = 32'h1234_0000;
    @(negedge clock);
    lb.load_valid = 1'b0;
    @(negedge clock);
    lb.load_valid = 1'b1; lb.load_data = 32'h1234_0001;
    @(negedge clock);
    lb.load_valid = 1'b0;
    do_reset();
    @(negedge clock);
    chk("midrst_boot_done", 32'(lb.boot_done), 32'd0);
    load_word(32'h1111_1111, 1'b1);
    chk("midrst_boot_after", 32'(lb.boot_done), 32'd1);
    fetch(26'd1, "midrst_pc1", 32'd0);
    fetch(26'd0, "midrst_pc0", 32'h1111_1111);
    chk("midrst_fault", 32'(lb.addr_fault), 32'd0);

`ifdef IMEM_RELOAD_EN
    fetch(26'd300, "pre_reload_fault", 32'd0);
    chk("pre_reload_fault_flag", 32'(lb.addr_fault), 32'd1);
    reload = 1'b1;
    lb.fetch_en = 1'b1;
    lb.pc = 26'd0;
    @(negedge clock);
    reload = 1'b0;
    lb.fetch_en = 1'b0;
    chk("reload_instr_valid", 32'(lb.instr_valid), 32'd0);
    chk("reload_boot_done", 32'(lb.boot_done), 32'd0);
    chk("reload_fault_clr", 32'(lb.addr_fault), 32'd0);
    chk("reload_load_ready", 32'(lb.load_ready), 32'd1);
    load_word(32'h2222_2222, 1'b1);
    chk("reload_boot_again", 32'(lb.boot_done), 32'd1);
    fetch(26'd0, "reload_pc0", 32'h2222_2222);
    fetch(26'd1, "reload_pc1", 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
